// File: rtl/led_status_driver_pkg.sv
// Shared definitions for the RGB status LED driver: FSM encodings and the
// colour decode helper used to build the active-low LED vector.
package led_status_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_PASS   = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  // Colour index doubles as the bit position in the {blu, grn, red} vector.
  typedef enum logic [1:0] {
    COL_RED  = 2'd0,
    COL_GRN  = 2'd1,
    COL_BLU  = 2'd2,
    COL_NONE = 2'd3
  } colour_t;

  function automatic logic [2:0] colour_n(input colour_t col, input logic on);
    logic [2:0] v;
    case (col)
      COL_RED: v = {2'b11, ~on};
      COL_GRN: v = {1'b1, ~on, 1'b1};
      COL_BLU: v = {~on, 2'b11};
      default: v = 3'b111;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_status_driver_pwm_blink_timebase.sv
// Free-running PWM counter plus a prescaler that toggles the blink phase
// BLINK_HZ full periods per second.
module led_status_driver_pwm_blink_timebase #(
  parameter int unsigned CLK_HZ   = 12000000,
  parameter int unsigned BLINK_HZ = 2,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                blink_phase
);

  localparam int unsigned PRESCALE = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    presc_r;
  logic [PWM_BITS-1:0] pwm_r;
  logic                phase_r;

  // Prescaler, blink phase and PWM counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc_r <= '0;
      pwm_r   <= '0;
      phase_r <= 1'b1;
    end else begin
      pwm_r <= pwm_r + PWM_BITS'(1'b1);
      if (presc_r == PRE_MAX) begin
        presc_r <= '0;
        phase_r <= ~phase_r;
      end else begin
        presc_r <= presc_r + PRE_W'(1'b1);
      end
    end
  end

  assign pwm_cnt     = pwm_r;
  assign blink_phase = phase_r;

endmodule

// File: rtl/led_status_driver.sv
// RGB status LED driver: dim blue idle, solid blue arming, solid green after
// PASS_COUNT consecutive passes, blinking red on sticky failure.
module led_status_driver
  import led_status_driver_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned BLINK_HZ    = 2,
  parameter int unsigned PASS_COUNT  = 4,
  parameter int unsigned TIMEOUT_CYC = 12000000,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned IDLE_DUTY   = 32
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       check_valid,
  input  logic       check_pass,
  input  logic       clear,
  output logic       LED_RED_N,
  output logic       LED_GRN_N,
  output logic       LED_BLU_N,
  output logic [1:0] state,
  output logic [7:0] fail_count
);

  localparam int unsigned PC_W = $clog2(PASS_COUNT + 1);
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PC_W-1:0]     PC_TARGET = PC_W'(PASS_COUNT);
  localparam logic [TO_W-1:0]     TO_MAX    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [PWM_BITS-1:0] DUTY      = PWM_BITS'(IDLE_DUTY);

  state_t              state_r, state_nxt_s;
  logic [PC_W-1:0]     pass_cnt_r, pass_cnt_nxt_s, pass_inc_s;
  logic [7:0]          fail_cnt_r, fail_cnt_nxt_s;
  logic [TO_W-1:0]     to_cnt_r, to_cnt_nxt_s;
  logic [2:0]          led_n_r, led_n_nxt_s;
  logic [PWM_BITS-1:0] pwm_cnt_s;
  logic                blink_phase_s;
  logic                chk_s, timeout_s;

  led_status_driver_pwm_blink_timebase #(
    .CLK_HZ   (CLK_HZ),
    .BLINK_HZ (BLINK_HZ),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .pwm_cnt     (pwm_cnt_s),
    .blink_phase (blink_phase_s)
  );

  // Next-state, counters and LED decode.
  always_comb begin
    state_nxt_s    = state_r;
    pass_cnt_nxt_s = pass_cnt_r;
    fail_cnt_nxt_s = fail_cnt_r;
    to_cnt_nxt_s   = to_cnt_r;
    led_n_nxt_s    = 3'b111;
    // clear drops any check arriving in the same cycle
    chk_s      = check_valid & ~clear;
    timeout_s  = (to_cnt_r == TO_MAX) & ~check_valid;
    pass_inc_s = pass_cnt_r + PC_W'(1'b1);

    if (clear) begin
      fail_cnt_nxt_s = 8'd0;
    end else if (chk_s && !check_pass && fail_cnt_r != 8'hFF) begin
      fail_cnt_nxt_s = fail_cnt_r + 8'd1;
    end else begin
      fail_cnt_nxt_s = fail_cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (chk_s && check_pass) begin
          pass_cnt_nxt_s = PC_W'(1'b1);
          state_nxt_s    = (PASS_COUNT == 32'd1) ? ST_PASS : ST_ARMING;
        end else if (chk_s) begin
          state_nxt_s = ST_FAIL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMING: begin
        if (chk_s && check_pass) begin
          pass_cnt_nxt_s = pass_inc_s;
          state_nxt_s    = (pass_inc_s == PC_TARGET) ? ST_PASS : ST_ARMING;
        end else if (chk_s) begin
          state_nxt_s = ST_FAIL;
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARMING;
        end
      end
      ST_PASS: begin
        if (chk_s && !check_pass) begin
          state_nxt_s = ST_FAIL;
        end else if (!chk_s && timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PASS;
        end
      end
      ST_FAIL: begin
        if (clear) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FAIL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    if (state_nxt_s == ST_IDLE || state_nxt_s == ST_FAIL) begin
      pass_cnt_nxt_s = '0;
    end else begin
      pass_cnt_nxt_s = pass_cnt_nxt_s;
    end

    if (check_valid || state_nxt_s != state_r) begin
      to_cnt_nxt_s = '0;
    end else if (to_cnt_r != TO_MAX) begin
      to_cnt_nxt_s = to_cnt_r + TO_W'(1'b1);
    end else begin
      to_cnt_nxt_s = to_cnt_r;
    end

    case (state_r)
      ST_IDLE:   led_n_nxt_s = colour_n(COL_BLU, pwm_cnt_s < DUTY);
      ST_ARMING: led_n_nxt_s = colour_n(COL_BLU, 1'b1);
      ST_PASS:   led_n_nxt_s = colour_n(COL_GRN, 1'b1);
      ST_FAIL:   led_n_nxt_s = colour_n(COL_RED, blink_phase_s);
      default:   led_n_nxt_s = 3'b111;
    endcase
  end

  // State, counter and LED output registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      pass_cnt_r <= '0;
      fail_cnt_r <= 8'd0;
      to_cnt_r   <= '0;
      led_n_r    <= 3'b111;
    end else begin
      state_r    <= state_nxt_s;
      pass_cnt_r <= pass_cnt_nxt_s;
      fail_cnt_r <= fail_cnt_nxt_s;
      to_cnt_r   <= to_cnt_nxt_s;
      led_n_r    <= led_n_nxt_s;
    end
  end

  assign LED_RED_N  = led_n_r[COL_RED];
  assign LED_GRN_N  = led_n_r[COL_GRN];
  assign LED_BLU_N  = led_n_r[COL_BLU];
  assign state      = state_r;
  assign fail_count = fail_cnt_r;

endmodule

// File: tb/tb_led_status_driver.sv
// Directed bench for led_status_driver: a vector table for the FSM and
// hand sequences for PWM, blink, timeout, saturation and mid-run reset.
module tb_led_status_driver;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       check_valid, check_pass, clear;
  logic       LED_RED_N, LED_GRN_N, LED_BLU_N;
  logic [1:0] state;
  logic [7:0] fail_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic       p;
    logic       c;
    logic [1:0] st;
    logic [7:0] fc;
  } vec_t;

  vec_t vecs[16];

  led_status_driver #(
    .CLK_HZ      (16),
    .BLINK_HZ    (2),
    .PASS_COUNT  (4),
    .TIMEOUT_CYC (20),
    .PWM_BITS    (3),
    .IDLE_DUTY   (2)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .check_valid (check_valid),
    .check_pass  (check_pass),
    .clear       (clear),
    .LED_RED_N   (LED_RED_N),
    .LED_GRN_N   (LED_GRN_N),
    .LED_BLU_N   (LED_BLU_N),
    .state       (state),
    .fail_count  (fail_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs for one edge, then release them 1ns after the edge.
  task automatic step(input logic v, input logic p, input logic c);
    check_valid = v;
    check_pass  = p;
    clear       = c;
    @(posedge CLK);
    #1;
    check_valid = 1'b0;
    check_pass  = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  function automatic int leds();
    return {29'd0, LED_BLU_N, LED_GRN_N, LED_RED_N};
  endfunction

  initial begin
    int lows, others, prev, last, changes;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd1, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd1, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd1, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 2'd1, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd1, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd2, 8'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd2, 8'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'd3, 8'd1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd3, 8'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd3, 8'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd0, 8'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 2'd3, 8'd1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 2'd3, 8'd1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 2'd0, 8'd0};

    check_valid = 1'b0;
    check_pass  = 1'b0;
    clear       = 1'b0;
    RST_N       = 1'b0;
    idle(2);
    check("reset_leds", leds(), 7);
    check("reset_state", state, 0);
    check("reset_fail_count", fail_count, 0);
    RST_N = 1'b1;

    // Idle PWM: blue low 2 of every 8 cycles.
    lows = 0;
    others = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (!LED_BLU_N) lows++;
      if (!LED_RED_N || !LED_GRN_N) others++;
    end
    check("idle_pwm_blue_lows", lows, 4);
    check("idle_other_colours", others, 0);

    // Four passes three cycles apart.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("arming_state", state, (i < 3) ? 1 : 2);
      if (i < 3) begin
        idle(2);
        check("arming_blue_solid", leds(), 3);
      end else begin
        check("pass_led_latency_early", LED_GRN_N, 1);
        idle(1);
        check("pass_green_on", leds(), 5);
        idle(1);
      end
    end

    // Fail while in PASS, then watch the red blink.
    step(1'b1, 1'b0, 1'b0);
    check("fail_state", state, 3);
    check("fail_count_1", fail_count, 1);
    idle(1);
    prev = LED_RED_N;
    last = -1;
    changes = 0;
    others = 0;
    for (int i = 0; i < 24; i++) begin
      idle(1);
      if (!LED_GRN_N || !LED_BLU_N) others++;
      if (LED_RED_N != prev) begin
        if (last >= 0) check("blink_interval", i - last, 4);
        last = i;
        changes++;
        prev = LED_RED_N;
      end
    end
    check("blink_changes", changes, 6);
    check("fail_other_colours", others, 0);
    step(1'b1, 1'b1, 1'b0);
    check("fail_sticky_state", state, 3);
    check("fail_sticky_count", fail_count, 1);

    // Clear together with a fail strobe: clear wins.
    step(1'b1, 1'b0, 1'b1);
    check("clear_fail_state", state, 0);
    check("clear_fail_count", fail_count, 0);
    idle(1);
    check("clear_red_off", LED_RED_N, 1);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].v, vecs[i].p, vecs[i].c);
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      check($sformatf("vec%0d_fail_count", i), fail_count, vecs[i].fc);
    end

    // Timeout from PASS back to IDLE after 20 quiet cycles.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    check("to_reach_pass", state, 2);
    idle(19);
    check("to_before_expiry", state, 2);
    idle(1);
    check("to_expired", state, 0);
    idle(1);
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (!LED_BLU_N) lows++;
    end
    check("to_pwm_resumed", lows, 2);

    // A strobe on the 20th cycle holds PASS and restarts the count.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    check("to2_reach_pass", state, 2);
    idle(19);
    step(1'b1, 1'b1, 1'b0);
    check("to2_strobe_keeps_pass", state, 2);
    idle(19);
    check("to2_restarted", state, 2);
    idle(1);
    check("to2_expired", state, 0);

    // Saturation, then a one-cycle reset mid-blink.
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
    check("sat_fail_count", fail_count, 255);
    check("sat_state", state, 3);
    idle(5);
    RST_N = 1'b0;
    idle(1);
    check("midreset_leds", leds(), 7);
    check("midreset_state", state, 0);
    check("midreset_fail_count", fail_count, 0);
    RST_N = 1'b1;
    idle(1);
    check("midreset_pwm0_blue", LED_BLU_N, 0);
    idle(1);
    check("midreset_pwm1_blue", LED_BLU_N, 0);
    idle(1);
    check("midreset_pwm2_blue", LED_BLU_N, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
